ctrl_seq_unit: RTL and testbench
================================

Name: ctrl_seq_unit

Overview:
- Instruction sequencer for the 6-bit CPU.
- Fetches 6-bit instructions over a valid/req handshake and steps a FETCH/DECODE/EXEC/WB state machine.
- Drives the 3-bit register select into dec_3_to_8 (reg_sel -> A) and qualifies the decoder's one-hot output with reg_we.
- Also drives ALU op and accumulator-load strobes to the datapath.

Parameters:
- PC_W, 6, program counter width; wraps modulo 2^PC_W.
- INSTR_W, 6, instruction width; fixed split: opcode [5:3], register field [2:0].
- RST_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_req  out  1  high in FETCH: requesting instruction at pc.
- pc  out  PC_W  current fetch address.
- instr_valid  in  1  instr_data valid; sampled only while instr_req=1.
- instr_data  in  INSTR_W  fetched instruction.
- reg_sel  out  3  register index to dec_3_to_8 input A.
- reg_we  out  1  write strobe; gates decoder output Y into register-file enables.
- alu_op  out  3  ALU operation code, valid while alu_en=1.
- alu_en  out  1  ALU operation this cycle.
- acc_load  out  1  accumulator captures ALU/register result this cycle.
- halted  out  1  sequencer stopped on HLT.

Behaviour:
- Reset (async assert, sync release): state=FETCH, pc=RST_PC, ir=0, reg_sel=0; reg_we, alu_en, acc_load, instr_req, halted all 0; alu_op=0.
  - All outputs are registered.
  - instr_req asserts in the first cycle after reset release.
- States: FETCH, DECODE, EXEC, WB, HALT.
- FETCH:
  - instr_req=1.
  - If instr_valid=1: ir<=instr_data, pc<=pc+1 (wraps 2^PC_W-1 -> 0), go to DECODE.
  - Else hold in FETCH with pc stable.
- DECODE:
  - instr_req=0.
  - reg_sel<=ir[2:0]; reg_sel then holds until the next DECODE.
  - Opcode 111 -> HALT; otherwise -> EXEC.
- EXEC (one cycle), by opcode:
  - 000 NOP: no strobes.
  - 001 LOAD: acc_load=1, alu_op=000 (pass), alu_en=1.
  - 010 STORE: no EXEC strobes.
  - 011 ADD: alu_op=001, alu_en=1, acc_load=1.
  - 100 SUB: alu_op=010, alu_en=1, acc_load=1.
  - 101 INC: alu_op=011, alu_en=1.
  - 110 CLR: alu_op=100, alu_en=1.
  - Always -> WB.
- WB (one cycle):
  - reg_we=1 only for STORE, INC, CLR; reg_sel stable throughout.
  - -> FETCH.
- HALT:
  - halted=1; all strobes 0; pc frozen.
  - Exit only via rst_n.
- Latency:
  - 4 cycles per instruction when instr_valid is high in the first FETCH cycle.
  - Each FETCH wait cycle adds one cycle.
- Strobe rules:
  - reg_we and acc_load are never high in the same cycle.
  - Strobes are single-cycle pulses.
- instr_valid outside FETCH is ignored; instr_data is not captured.
- Reset mid-instruction: all outputs return to reset values immediately (asynchronous); any pending write is dropped.

Optional Feature:
- Macro CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit) and state PAUSE.
  - WB -> PAUSE instead of FETCH.
  - PAUSE holds with all strobes 0 until step=1 is sampled, then -> FETCH.
  - A step held high advances one instruction per pass through PAUSE.
  - HALT ignores step.
- Undefined: no step port, no PAUSE state; WB -> FETCH directly.

Decomposition:
- Shared package/include ctrl_defs.vh holds:
  - state encodings: FETCH, DECODE, EXEC, WB, HALT, PAUSE;
  - opcode constants OP_NOP..OP_HLT;
  - ALU op constants ALU_PASS, ALU_ADD, ALU_SUB, ALU_INC, ALU_CLR.
- One natural sub-module: ctrl_op_decode. Purely combinational; maps opcode to {alu_op, alu_en, acc_load_req, reg_we_req, is_halt}. The FSM registers these into the outputs.

Test Plan:
- Reset then instr_valid=1 with instr_data=6'b010_101 (STORE r5) -> cycle 1: instr_req=1, pc=0; cycle 2: reg_sel=3'b101; cycle 4: reg_we=1; dec_3_to_8 Y=8'b0010_0000; pc=1.
- ADD r2 (6'b011_010), instr_valid delayed 3 cycles -> pc held at 0 for 3 cycles; EXEC: alu_op=001, alu_en=1, acc_load=1; reg_we stays 0.
- Sequence NOP, INC r7, HLT -> reg_we pulses once with reg_sel=7; after HLT decode, halted=1, pc=3, no further instr_req.
- Preload pc to 63 via RST_PC=63 -> after one fetch, pc=0 (wrap).
- Assert rst_n=0 during WB of CLR r1 -> reg_we drops same cycle without waiting for clk; after release, state=FETCH, pc=RST_PC.
- With CTRL_SINGLE_STEP_EN: two NOPs, step=0 -> sequencer sits in PAUSE with instr_req=0; step pulse -> exactly one further fetch.

Source files
------------

// File: rtl/ctrl_seq_unit_pkg.sv
// Shared encodings for the ctrl_seq_unit instruction sequencer.
// State, opcode and ALU-op constants plus the decode bundle.
package ctrl_seq_unit_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_HALT   = 3'd4,
      ST_PAUSE  = 3'd5
   } state_t;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_STORE = 3'b010;
   localparam logic [2:0] OP_ADD   = 3'b011;
   localparam logic [2:0] OP_SUB   = 3'b100;
   localparam logic [2:0] OP_INC   = 3'b101;
   localparam logic [2:0] OP_CLR   = 3'b110;
   localparam logic [2:0] OP_HLT   = 3'b111;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_INC  = 3'b011;
   localparam logic [2:0] ALU_CLR  = 3'b100;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       alu_en;
      logic       acc_load_req;
      logic       reg_we_req;
      logic       is_halt;
   } op_ctrl_t;

endpackage

// File: rtl/ctrl_seq_unit_op_decode.sv
// Combinational opcode decoder: opcode -> ALU/strobe request bundle.
module ctrl_op_decode
   import ctrl_seq_unit_pkg::*;
(
   input  logic [2:0] op,
   output op_ctrl_t   ctl
);

   always_comb begin
      ctl = '0;
      unique case (op)
         OP_NOP:   ;
         OP_LOAD:  begin ctl.alu_op = ALU_PASS; ctl.alu_en = 1'b1; ctl.acc_load_req = 1'b1; end
         OP_STORE: ctl.reg_we_req = 1'b1;
         OP_ADD:   begin ctl.alu_op = ALU_ADD; ctl.alu_en = 1'b1; ctl.acc_load_req = 1'b1; end
         OP_SUB:   begin ctl.alu_op = ALU_SUB; ctl.alu_en = 1'b1; ctl.acc_load_req = 1'b1; end
         OP_INC:   begin ctl.alu_op = ALU_INC; ctl.alu_en = 1'b1; ctl.reg_we_req = 1'b1; end
         OP_CLR:   begin ctl.alu_op = ALU_CLR; ctl.alu_en = 1'b1; ctl.reg_we_req = 1'b1; end
         OP_HLT:   ctl.is_halt = 1'b1;
         default:  ;
      endcase
   end

endmodule

// File: rtl/ctrl_seq_unit.sv
// FETCH/DECODE/EXEC/WB instruction sequencer with registered strobes.
// Define CTRL_SINGLE_STEP_EN to add the step input and PAUSE state.
module ctrl_seq_unit
   import ctrl_seq_unit_pkg::*;
#(
   parameter int unsigned PC_W    = 6,
   parameter int unsigned INSTR_W = 6,
   parameter int unsigned RST_PC  = 0
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic               step,
`endif
   output logic               instr_req,
   output logic [PC_W-1:0]    pc,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr_data,
   output logic [2:0]         reg_sel,
   output logic               reg_we,
   output logic [2:0]         alu_op,
   output logic               alu_en,
   output logic               acc_load,
   output logic               halted
);

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [2:0]         reg_sel_q, reg_sel_d;
   logic [2:0]         alu_op_q, alu_op_d;
   logic               instr_req_q, instr_req_d;
   logic               reg_we_q, reg_we_d;
   logic               alu_en_q, alu_en_d;
   logic               acc_load_q, acc_load_d;
   logic               halted_q, halted_d;
   op_ctrl_t           dec;

   ctrl_op_decode u_dec (
      .op  (ir_q[INSTR_W-1 -: 3]),
      .ctl (dec)
   );

   // Outputs are computed for the state being entered, so they are
   // registered yet line up with that state's cycle.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      reg_sel_d   = reg_sel_q;
      instr_req_d = 1'b0;
      reg_we_d    = 1'b0;
      alu_op_d    = ALU_PASS;
      alu_en_d    = 1'b0;
      acc_load_d  = 1'b0;
      halted_d    = 1'b0;
      unique case (state_q)
         ST_FETCH: begin
            instr_req_d = 1'b1;
            if (instr_req_q && instr_valid) begin
               ir_d        = instr_data;
               pc_d        = pc_q + 1'b1;
               reg_sel_d   = instr_data[2:0];
               instr_req_d = 1'b0;
               state_d     = ST_DECODE;
            end
         end
         ST_DECODE: begin
            reg_sel_d = ir_q[2:0];
            if (dec.is_halt) begin
               halted_d = 1'b1;
               state_d  = ST_HALT;
            end else begin
               alu_op_d   = dec.alu_op;
               alu_en_d   = dec.alu_en;
               acc_load_d = dec.acc_load_req;
               state_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            reg_we_d = dec.reg_we_req;
            state_d  = ST_WB;
         end
         ST_WB: begin
`ifdef CTRL_SINGLE_STEP_EN
            state_d = ST_PAUSE;
`else
            instr_req_d = 1'b1;
            state_d     = ST_FETCH;
`endif
         end
`ifdef CTRL_SINGLE_STEP_EN
         ST_PAUSE: begin
            if (step) begin
               instr_req_d = 1'b1;
               state_d     = ST_FETCH;
            end
         end
`endif
         ST_HALT: halted_d = 1'b1;
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FETCH;
         pc_q        <= PC_W'(RST_PC);
         ir_q        <= '0;
         reg_sel_q   <= '0;
         instr_req_q <= 1'b0;
         reg_we_q    <= 1'b0;
         alu_op_q    <= ALU_PASS;
         alu_en_q    <= 1'b0;
         acc_load_q  <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         reg_sel_q   <= reg_sel_d;
         instr_req_q <= instr_req_d;
         reg_we_q    <= reg_we_d;
         alu_op_q    <= alu_op_d;
         alu_en_q    <= alu_en_d;
         acc_load_q  <= acc_load_d;
         halted_q    <= halted_d;
      end
   end

   assign instr_req = instr_req_q;
   assign pc        = pc_q;
   assign reg_sel   = reg_sel_q;
   assign reg_we    = reg_we_q;
   assign alu_op    = alu_op_q;
   assign alu_en    = alu_en_q;
   assign acc_load  = acc_load_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Self-checking bench for ctrl_seq_unit: timeline model plus directed checks.
// Builds with or without CTRL_SINGLE_STEP_EN.
module tb_ctrl_seq_unit;

`ifdef CTRL_SINGLE_STEP_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       step = 1'b0;
   logic       instr_valid = 1'b0;
   logic [5:0] instr_data = '0;
   logic       instr_req, reg_we, alu_en, acc_load, halted;
   logic [5:0] pc;
   logic [2:0] reg_sel, alu_op;
   logic       w_req, w_we, w_en, w_acc, w_halt;
   logic [5:0] w_pc;
   logic [2:0] w_sel, w_op;

   int total = 0;
   int bad = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   ctrl_seq_unit dut (
      .clk(clk), .rst_n(rst_n),
`ifdef CTRL_SINGLE_STEP_EN
      .step(step),
`endif
      .instr_req(instr_req), .pc(pc),
      .instr_valid(instr_valid), .instr_data(instr_data),
      .reg_sel(reg_sel), .reg_we(reg_we), .alu_op(alu_op),
      .alu_en(alu_en), .acc_load(acc_load), .halted(halted)
   );

   ctrl_seq_unit #(.RST_PC(63)) u_wrap (
      .clk(clk), .rst_n(rst_n),
`ifdef CTRL_SINGLE_STEP_EN
      .step(step),
`endif
      .instr_req(w_req), .pc(w_pc),
      .instr_valid(instr_valid), .instr_data(instr_data),
      .reg_sel(w_sel), .reg_we(w_we), .alu_op(w_op),
      .alu_en(w_en), .acc_load(w_acc), .halted(w_halt)
   );

   // Per-opcode behaviour, bit i = opcode i.
   localparam logic [7:0] T_EN  = 8'b0111_1010;
   localparam logic [7:0] T_ACC = 8'b0001_1010;
   localparam logic [7:0] T_WE  = 8'b0110_0100;

   function automatic logic [2:0] alu_code(input logic [2:0] op);
      case (op)
         3'd3: return 3'd1;
         3'd4: return 3'd2;
         3'd5: return 3'd3;
         3'd6: return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   // Instruction timeline: 0 fetch, 1 decode, 2 exec, 3 wb, 4 pause, 5 halted.
   int         m_ph;
   bit         m_armed;
   logic [5:0] m_pc;
   logic [2:0] m_op, m_rs;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph <= 0; m_armed <= 1'b0; m_pc <= '0; m_op <= '0; m_rs <= '0;
      end else begin
         m_armed <= 1'b1;
         case (m_ph)
            0: if (m_armed && instr_valid) begin
                  m_op <= instr_data[5:3];
                  m_rs <= instr_data[2:0];
                  m_pc <= m_pc + 6'd1;
                  m_ph <= 1;
               end
            1: m_ph <= (m_op == 3'd7) ? 5 : 2;
            2: m_ph <= 3;
            3: m_ph <= STEP_EN ? 4 : 0;
            4: if (step) m_ph <= 0;
            default: ;
         endcase
      end
   end

   logic e_req, e_en, e_acc, e_we, e_halt;
   assign e_req  = (m_ph == 0) && m_armed;
   assign e_en   = (m_ph == 2) && T_EN[m_op];
   assign e_acc  = (m_ph == 2) && T_ACC[m_op];
   assign e_we   = (m_ph == 3) && T_WE[m_op];
   assign e_halt = (m_ph == 5);

   always @(negedge clk) begin
      if (cmp_en) begin
         total++;
         if ({instr_req, pc, reg_sel, reg_we, alu_en, acc_load, halted} !==
             {e_req, m_pc, m_rs, e_we, e_en, e_acc, e_halt}) begin
            bad++;
            $display("FAIL cycle_outputs t=%0t got req=%b pc=%0d sel=%0d we=%b en=%b acc=%b hlt=%b need req=%b pc=%0d sel=%0d we=%b en=%b acc=%b hlt=%b",
                     $time, instr_req, pc, reg_sel, reg_we, alu_en, acc_load, halted,
                     e_req, m_pc, m_rs, e_we, e_en, e_acc, e_halt);
         end
         if (e_en) begin
            total++;
            if (alu_op !== alu_code(m_op)) begin
               bad++;
               $display("FAIL cycle_alu_op t=%0t got=%0d need=%0d", $time, alu_op, alu_code(m_op));
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
      total++;
      if (got !== need) begin
         bad++;
         $display("FAIL %s got=%0h need=%0h", name, got, need);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; instr_valid = 1'b0; instr_data = '0; step = 1'b0;
      tick(); tick();
      cmp_en = 1'b1;
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic [5:0] d);
      int n;
      instr_data = d;
      instr_valid = 1'b1;
      n = 0;
      while (!instr_req && n < 20) begin
         tick();
         n++;
      end
      if (!instr_req) begin
         bad++; total++;
         $display("FAIL issue_timeout got=instr_req_low need=instr_req_high");
      end
      tick();
      instr_valid = 1'b0;
   endtask

   int cnt;
   logic [2:0] sel_seen;
   logic [7:0] y;

   initial begin
      // STORE r5 straight after reset, plus RST_PC=63 wrap on u_wrap
      do_reset();
      chk("rst_req", instr_req, 0);
      chk("rst_pc", pc, 0);
      chk("wrap_rst_pc", w_pc, 63);
      instr_valid = 1'b1; instr_data = 6'b010_101;
      tick();
      chk("st_c1_req", instr_req, 1);
      chk("st_c1_pc", pc, 0);
      tick();
      instr_valid = 1'b0;
      chk("st_c2_sel", reg_sel, 5);
      chk("wrap_pc", w_pc, 0);
      tick(); tick();
      y = reg_we ? (8'd1 << reg_sel) : 8'd0;
      chk("st_c4_we", reg_we, 1);
      chk("st_c4_y", y, 8'b0010_0000);
      chk("st_c4_pc", pc, 1);

      // ADD r2 with instr_valid held off for three FETCH cycles
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("add_wait_pc", pc, 0);
      end
      instr_valid = 1'b1; instr_data = 6'b011_010;
      tick();
      instr_valid = 1'b0;
      tick();
      chk("add_alu_op", alu_op, 1);
      chk("add_alu_en", alu_en, 1);
      chk("add_acc", acc_load, 1);
      chk("add_we", reg_we, 0);
      tick();
      chk("add_wb_we", reg_we, 0);

      // NOP, INC r7, HLT
      do_reset();
      issue(6'b000_000);
      issue(6'b101_111);
      cnt = 0; sel_seen = '0;
      for (int i = 0; i < 4; i++) begin
         if (reg_we) begin cnt++; sel_seen = reg_sel; end
         tick();
      end
      chk("inc_we_pulses", cnt, 1);
      chk("inc_we_sel", sel_seen, 7);
      issue(6'b111_000);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (instr_req) cnt++;
      end
      chk("hlt_halted", halted, 1);
      chk("hlt_pc", pc, 3);
      chk("hlt_no_req", cnt, 0);

      // Async reset while CLR r1 is in WB
      do_reset();
      issue(6'b110_001);
      tick(); tick();
      chk("clr_wb_we", reg_we, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("clr_rst_we", reg_we, 0);
      chk("clr_rst_pc", pc, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
      chk("clr_rel_req", instr_req, 1);
      chk("clr_rel_pc", pc, 0);

`ifdef CTRL_SINGLE_STEP_EN
      // Single step: NOP parks in PAUSE until one step pulse
      do_reset();
      issue(6'b000_000);
      tick(); tick(); tick();
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (instr_req) cnt++;
         tick();
      end
      chk("pause_no_req", cnt, 0);
      step = 1'b1;
      tick();
      step = 1'b0;
      issue(6'b000_000);
      instr_valid = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (instr_req) cnt++;
      end
      instr_valid = 1'b0;
      chk("step_one_fetch", cnt, 0);
      chk("step_pc", pc, 2);
`endif

      tick();
      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
